// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: queued one-hot row writes, two-port pipelined reads
// with write-queue forwarding so reads always observe every previously accepted write.
module regfile_access_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int WQ_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Rst_N,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_hold,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic [NUM_REGS-1:0] WriteSelect,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] ReadA,
    output logic [NUM_REGS-1:0] ReadB,
    input  logic [DATA_W-1:0]   BusA,
    input  logic [DATA_W-1:0]   BusB
);

    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Out-of-range addresses decode to all-zero, which doubles as the range check.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) sel[i] = 1'b1;
        end
        return sel;
    endfunction

    logic [ADDR_W-1:0] q_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] q_data_q [WQ_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_a_q, s1_addr_a_d;
    logic [ADDR_W-1:0] s1_addr_b_q, s1_addr_b_d;

    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

    logic              push;
    logic              drain;
    logic [NUM_REGS-1:0] read_en_a;
    logic [NUM_REGS-1:0] read_en_b;
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit_a, fwd_hit_b;
    logic [DATA_W-1:0] fwd_data_a, fwd_data_b;
    logic [DATA_W-1:0] result_a, result_b;

    assign wr_ready = (count_q != CNT_W'(WQ_DEPTH));
    assign push     = wr_valid && wr_ready;
    // A drain during the reset cycle would corrupt cells with discarded data.
    assign drain    = Rst_N && (count_q != '0) && !wr_hold;

    assign WriteSelect = drain ? onehot(q_addr_q[rd_ptr_q]) : '0;
    assign WriteData   = drain ? q_data_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (drain) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            q_addr_q[wr_ptr_q] <= wr_addr;
            q_data_q[wr_ptr_q] <= wr_data;
        end
    end

    assign read_en_a = s1_valid_q ? onehot(s1_addr_a_q) : '0;
    assign read_en_b = s1_valid_q ? onehot(s1_addr_b_q) : '0;
    assign ReadA     = read_en_a;
    assign ReadB     = read_en_b;

    // Walk entries oldest to youngest so the youngest matching write wins.
    always_comb begin
        fwd_idx    = '0;
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        for (int k = 0; k < WQ_DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (q_addr_q[fwd_idx] == s1_addr_a_q) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = q_data_q[fwd_idx];
                end
                if (q_addr_q[fwd_idx] == s1_addr_b_q) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = q_data_q[fwd_idx];
                end
            end
        end
    end

    always_comb begin
        result_a = '0;
        result_b = '0;
        if (read_en_a != '0) result_a = fwd_hit_a ? fwd_data_a : BusA;
        if (read_en_b != '0) result_b = fwd_hit_b ? fwd_data_b : BusB;
    end

    always_comb begin
        s1_valid_d  = rd_req;
        s1_addr_a_d = rd_req ? rd_addr_a : s1_addr_a_q;
        s1_addr_b_d = rd_req ? rd_addr_b : s1_addr_b_q;
        rd_valid_d  = s1_valid_q;
        rd_data_a_d = s1_valid_q ? result_a : rd_data_a_q;
        rd_data_b_d = s1_valid_q ? result_b : rd_data_b_q;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_a_q <= '0;
            s1_addr_b_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_a_q <= s1_addr_a_d;
            s1_addr_b_q <= s1_addr_b_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl built with NUM_REGS=6 so addresses 6 and 7 are out of range;
// includes a behavioural cell array driving BusA/BusB from ReadA/ReadB.
module tb_regfile_access_ctrl;

    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int WQ_DEPTH = 4;

    logic                Clk;
    logic                Rst_N;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_hold;
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic [NUM_REGS-1:0] WriteSelect;
    logic [DATA_W-1:0]   WriteData;
    logic [NUM_REGS-1:0] ReadA;
    logic [NUM_REGS-1:0] ReadB;
    logic [DATA_W-1:0]   BusA;
    logic [DATA_W-1:0]   BusB;

    int checks = 0;
    int errors = 0;

    regfile_access_ctrl #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)
    ) dut (
        .Clk(Clk), .Rst_N(Rst_N),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_hold(wr_hold),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .WriteSelect(WriteSelect), .WriteData(WriteData),
        .ReadA(ReadA), .ReadB(ReadB), .BusA(BusA), .BusB(BusB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Physical cell array; an idle bus floats to a garbage value that must never be used.
    logic [DATA_W-1:0] cells [NUM_REGS] = '{default: '0};

    always @(posedge Clk) begin
        for (int i = 0; i < NUM_REGS; i++)
            if (WriteSelect[i]) cells[i] <= WriteData;
    end

    always_comb begin
        BusA = 8'hEE;
        BusB = 8'hEE;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ReadA[i]) BusA = cells[i];
            if (ReadB[i]) BusB = cells[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pending writes are a plain queue, cells a plain array; a read sees the
    // youngest pending write to its address, else the cell contents.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] mem_m [NUM_REGS] = '{default: '0};
    logic              chk_en = 1'b0;
    logic              m_s1_v = 1'b0;
    int                m_s1_aa, m_s1_ab;
    logic [DATA_W-1:0] m_s1_da, m_s1_db;
    logic              m_rdv = 1'b0;
    logic [DATA_W-1:0] m_da = '0, m_db = '0;
    logic              m_full, m_drain;

    function automatic logic [DATA_W-1:0] m_read(input int a);
        logic [DATA_W-1:0] v;
        if (a >= NUM_REGS) return '0;
        v = mem_m[a];
        foreach (mq[i]) if (int'(mq[i].a) == a) v = mq[i].d;
        return v;
    endfunction

    always @(posedge Clk) begin
        if (!Rst_N) begin
            mq.delete();
            m_s1_v = 1'b0;
            m_rdv  = 1'b0;
            m_da   = '0;
            m_db   = '0;
            chk_en = 1'b1;
        end else begin
            m_full  = (mq.size() == WQ_DEPTH);
            m_drain = (mq.size() > 0) && !wr_hold;
            m_rdv   = m_s1_v;
            if (m_s1_v) begin
                m_da = m_s1_da;
                m_db = m_s1_db;
            end
            if (m_drain) begin
                if (int'(mq[0].a) < NUM_REGS) mem_m[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (wr_valid && !m_full) mq.push_back('{a: wr_addr, d: wr_data});
            m_s1_v = rd_req;
            if (rd_req) begin
                m_s1_aa = int'(rd_addr_a);
                m_s1_ab = int'(rd_addr_b);
                m_s1_da = m_read(m_s1_aa);
                m_s1_db = m_read(m_s1_ab);
            end
        end
    end

    logic [NUM_REGS-1:0] exp_ws, exp_ra, exp_rb;

    always @(negedge Clk) begin
        if (chk_en) begin
            exp_ws = '0;
            exp_ra = '0;
            exp_rb = '0;
            if (Rst_N && mq.size() > 0 && !wr_hold) begin
                if (int'(mq[0].a) < NUM_REGS) exp_ws[mq[0].a] = 1'b1;
                chk("m_wdata", 32'(WriteData), 32'(mq[0].d));
            end
            if (m_s1_v && m_s1_aa < NUM_REGS) exp_ra[m_s1_aa] = 1'b1;
            if (m_s1_v && m_s1_ab < NUM_REGS) exp_rb[m_s1_ab] = 1'b1;
            chk("m_wsel", 32'(WriteSelect), 32'(exp_ws));
            chk("m_wr_ready", 32'(wr_ready), 32'(mq.size() < WQ_DEPTH));
            chk("m_reada", 32'(ReadA), 32'(exp_ra));
            chk("m_readb", 32'(ReadB), 32'(exp_rb));
            chk("m_rd_valid", 32'(rd_valid), 32'(m_rdv));
            chk("m_rd_data_a", 32'(rd_data_a), 32'(m_da));
            chk("m_rd_data_b", 32'(rd_data_b), 32'(m_db));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [DATA_W-1:0]   exp5a [4] = '{8'h10, 8'h11, 8'h12, 8'hA5};
    logic [DATA_W-1:0]   exp5b [4] = '{8'hA5, 8'h12, 8'h11, 8'h10};
    logic [NUM_REGS-1:0] walk  [4] = '{6'b000001, 6'b000010, 6'b000100, 6'b010000};
    logic [ADDR_W-1:0]   waddr [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

    initial begin
        Rst_N = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_hold = 1'b0;
        rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        tick(); tick();
        Rst_N = 1'b1;
        @(negedge Clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data_a", 32'(rd_data_a), 32'd0);
        chk("rst_wsel", 32'(WriteSelect), 32'd0);

        // single write then read
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        @(negedge Clk);
        chk("w1_wsel", 32'(WriteSelect), 32'b001000);
        chk("w1_wdata", 32'(WriteData), 32'hA5);
        tick();
        @(negedge Clk);
        chk("w1_wsel_once", 32'(WriteSelect), 32'd0);
        tick();
        rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
        tick();
        rd_req = 1'b0;
        @(negedge Clk);
        chk("r1_reada", 32'(ReadA), 32'b001000);
        chk("r1_readb", 32'(ReadB), 32'b000001);
        tick();
        @(negedge Clk);
        chk("r1_valid", 32'(rd_valid), 32'd1);
        chk("r1_data_a", 32'(rd_data_a), 32'hA5);
        chk("r1_data_b", 32'(rd_data_b), 32'h00);
        tick();

        // fill queue under hold, then release
        wr_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = waddr[k]; wr_data = 8'(8'h10 + k);
            tick();
        end
        wr_addr = 3'd5; wr_data = 8'h99;
        @(negedge Clk);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0; wr_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("walk_wsel", 32'(WriteSelect), 32'(walk[k]));
            if (k == 0) chk("walk_ready0", 32'(wr_ready), 32'd0);
            if (k == 1) chk("walk_ready1", 32'(wr_ready), 32'd1);
            tick();
        end
        @(negedge Clk);
        chk("walk_no5th", 32'(WriteSelect), 32'd0);

        // forwarding
        wr_hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        tick();
        @(negedge Clk);
        chk("fwd1_valid", 32'(rd_valid), 32'd1);
        chk("fwd1_a", 32'(rd_data_a), 32'h3C);
        chk("fwd1_b", 32'(rd_data_b), 32'h3C);
        wr_valid = 1'b1; wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd3;
        tick();
        rd_req = 1'b0;
        tick();
        @(negedge Clk);
        chk("fwd2_a", 32'(rd_data_a), 32'h22);
        chk("fwd2_b", 32'(rd_data_b), 32'hA5);
        wr_hold = 1'b0;
        repeat (4) tick();

        // out-of-range addresses
        wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'h5A;
        rd_req = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd6;
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        @(negedge Clk);
        chk("oor_wsel", 32'(WriteSelect), 32'd0);
        chk("oor_reada", 32'(ReadA), 32'd0);
        tick();
        @(negedge Clk);
        chk("oor_valid", 32'(rd_valid), 32'd1);
        chk("oor_data_a", 32'(rd_data_a), 32'd0);
        chk("oor_data_b", 32'(rd_data_b), 32'd0);
        tick();

        // back-to-back reads
        for (int c = 0; c < 7; c++) begin
            rd_req = (c < 4);
            if (c < 4) begin
                rd_addr_a = 3'(c);
                rd_addr_b = 3'(3 - c);
            end
            @(negedge Clk);
            if (c >= 2 && c < 6) begin
                chk("b2b_valid", 32'(rd_valid), 32'd1);
                chk("b2b_a", 32'(rd_data_a), 32'(exp5a[c-2]));
                chk("b2b_b", 32'(rd_data_b), 32'(exp5b[c-2]));
            end
            if (c == 6) chk("b2b_end", 32'(rd_valid), 32'd0);
            tick();
        end

        // reset mid-operation
        wr_hold = 1'b1; wr_valid = 1'b1; wr_addr = 3'd1;
        wr_data = 8'h77; tick();
        wr_data = 8'h78; tick();
        wr_data = 8'h79; rd_req = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd2;
        tick();
        wr_valid = 1'b0; rd_req = 1'b0; wr_hold = 1'b0; Rst_N = 1'b0;
        @(negedge Clk);
        chk("mrst_wsel", 32'(WriteSelect), 32'd0);
        tick();
        Rst_N = 1'b1;
        @(negedge Clk);
        chk("mrst_valid", 32'(rd_valid), 32'd0);
        chk("mrst_ready", 32'(wr_ready), 32'd1);
        chk("mrst_wsel2", 32'(WriteSelect), 32'd0);
        rd_req = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd4;
        tick();
        rd_req = 1'b0;
        tick();
        @(negedge Clk);
        chk("mrst_keep_a", 32'(rd_data_a), 32'h11);
        chk("mrst_keep_b", 32'(rd_data_b), 32'h13);
        tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            Rst_N     = ($urandom_range(99) != 0);
            wr_valid  = 1'($urandom_range(1));
            wr_addr   = 3'($urandom_range(7));
            wr_data   = 8'($urandom);
            wr_hold   = ($urandom_range(9) < 3);
            rd_req    = 1'($urandom_range(1));
            rd_addr_a = 3'($urandom_range(7));
            rd_addr_b = 3'($urandom_range(7));
            tick();
        end
        Rst_N = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; wr_hold = 1'b0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
